// File: rtl/obi_ext_master_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one OBI master port.
// Address phases pass through with no added latency, and in-order responses are routed back through an ID FIFO.
module obi_ext_master_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             m_req_o,
    output logic                             m_we_o,
    output logic [DATA_WIDTH/8-1:0]          m_be_o,
    output logic [ADDR_WIDTH-1:0]            m_addr_o,
    output logic [DATA_WIDTH-1:0]            m_wdata_o,
    input  logic                             m_gnt_i,
    input  logic                             m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            m_rdata_i,
    output logic                             busy_o,
    output logic                             err_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  locked_id_q, locked_id_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];

    logic [ID_W-1:0]  sel_rr, sel, idx, head_id;
    logic             found, hs, pop;

    // Round-robin search starting at rr_ptr; the first requester found wins.
    always_comb begin
        sel_rr = rr_ptr_q;
        found  = 1'b0;
        idx    = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[idx]) begin
                sel_rr = idx;
                found  = 1'b1;
            end
            idx = (idx == ID_LAST) ? '0 : idx + ID_W'(1);
        end
    end

    assign sel       = lock_q ? locked_id_q : sel_rr;
    assign m_req_o   = (|req_i) && (count_q < CNT_MAX);
    assign m_we_o    = we_i[sel];
    assign m_be_o    = be_i[sel*BE_W +: BE_W];
    assign m_addr_o  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_o = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign hs        = m_req_o && m_gnt_i;
    assign pop       = m_rvalid_i && (count_q != '0);
    assign head_id   = fifo_q[rd_ptr_q];
    assign rdata_o   = m_rdata_i;
    assign busy_o    = (count_q != '0);
    assign err_o     = err_q;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs)  gnt_o[sel]        = 1'b1;
        if (pop) rvalid_o[head_id] = 1'b1;
    end

    // A stalled address phase pins the selection until the master grants it.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        if (hs) begin
            rr_ptr_d = (sel == ID_LAST) ? '0 : sel + ID_W'(1);
            lock_d   = 1'b0;
        end else if (m_req_o) begin
            lock_d      = 1'b1;
            locked_id_d = sel;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (m_rvalid_i && (count_q == '0));
        if (hs)  wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({hs, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            if (hs) fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_ext_master_arbiter.sv
// Bench for obi_ext_master_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_obi_ext_master_arbiter;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_i = '0;
    logic [NR-1:0]    we_i = '0;
    logic [AW-1:0]    addr_s [NR];
    logic [DW-1:0]    wdata_s [NR];
    logic [BW-1:0]    be_s [NR];
    logic [NR*BW-1:0] be_i;
    logic [NR*AW-1:0] addr_i;
    logic [NR*DW-1:0] wdata_i;
    logic [NR-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]    rdata_o, m_wdata_o, m_rdata_i = '0;
    logic             m_req_o, m_we_o, m_gnt_i = 1'b0, m_rvalid_i = 1'b0, busy_o, err_o;
    logic [BW-1:0]    m_be_o;
    logic [AW-1:0]    m_addr_o;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            addr_i[k*AW +: AW]  = addr_s[k];
            wdata_i[k*DW +: DW] = wdata_s[k];
            be_i[k*BW +: BW]    = be_s[k];
        end
    end

    obi_ext_master_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .busy_o(busy_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the outstanding IDs live in a queue, arbitration state in plain ints.
    logic [0:0] exp_q [$];
    int  m_rr = 0;
    bit  m_lock = 1'b0;
    int  m_locked = 0;
    bit  m_err = 1'b0;
    bit  exp_mreq, exp_hs, exp_pop;
    int  exp_sel;

    always @(negedge clk) begin
        exp_mreq = (req_i != '0) && (exp_q.size() < MO);
        if (m_lock) begin
            exp_sel = m_locked;
        end else begin
            exp_sel = m_rr;
            for (int i = NR - 1; i >= 0; i--)
                if (req_i[(m_rr + i) % NR]) exp_sel = (m_rr + i) % NR;
        end
        exp_hs  = exp_mreq && m_gnt_i;
        exp_pop = m_rvalid_i && (exp_q.size() > 0);
        if (rst_n) begin
            chk("m_req", 32'(m_req_o), 32'(exp_mreq));
            chk("gnt", 32'(gnt_o), exp_hs ? (32'd1 << exp_sel) : 32'd0);
            chk("rvalid", 32'(rvalid_o), exp_pop ? (32'd1 << exp_q[0]) : 32'd0);
            chk("busy", 32'(busy_o), 32'(exp_q.size() != 0));
            chk("err", 32'(err_o), 32'(m_err));
            if (exp_mreq) begin
                chk("m_addr", m_addr_o, addr_s[exp_sel]);
                chk("m_wdata", m_wdata_o, wdata_s[exp_sel]);
                chk("m_be", 32'(m_be_o), 32'(be_s[exp_sel]));
                chk("m_we", 32'(m_we_o), 32'(we_i[exp_sel]));
            end
            if (exp_pop) chk("rdata", rdata_o, m_rdata_i);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr = 0;
            m_lock = 1'b0;
            m_err = 1'b0;
            exp_q.delete();
        end else begin
            if (exp_pop) void'(exp_q.pop_front());
            else if (m_rvalid_i) m_err = 1'b1;
            if (exp_hs) begin
                exp_q.push_back(1'(exp_sel));
                m_rr = (exp_sel + 1) % NR;
                m_lock = 1'b0;
            end else if (exp_mreq) begin
                m_lock = 1'b1;
                m_locked = exp_sel;
            end
        end
    end

    task automatic set_in(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
        req_i = r;
        m_gnt_i = g;
        m_rvalid_i = rv;
        m_rdata_i = rd;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [1:0] gseq [4];
    logic [NR-1:0] pend;

    initial begin
        addr_s[0] = 32'h100; addr_s[1] = 32'h200;
        wdata_s[0] = 32'h1111_1111; wdata_s[1] = 32'h2222_2222;
        be_s[0] = 4'hF; be_s[1] = 4'h3;
        we_i = 2'b10;
        gseq[0] = 2'b01; gseq[1] = 2'b10; gseq[2] = 2'b01; gseq[3] = 2'b10;

        do_reset();
        // Reset state before any traffic
        settle();
        chk("rst_m_req", 32'(m_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        next_cyc();

        // Single transaction with zero-latency forwarding
        set_in(2'b01, 1'b1, 1'b0, 32'h0); settle();
        chk("t1_m_req", 32'(m_req_o), 32'd1);
        chk("t1_addr", m_addr_o, 32'h100);
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        next_cyc();
        set_in(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF); settle();
        chk("t1_rvalid", 32'(rvalid_o), 32'h1);
        chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        next_cyc();

        // Alternating grants with both requesters held high
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(2'b11, 1'b1, k > 0, 32'hA0 + 32'(k)); settle();
            chk("t2_gnt", 32'(gnt_o), 32'(gseq[k]));
            if (k > 0) chk("t2_rvalid", 32'(rvalid_o), 32'(gseq[k-1]));
            next_cyc();
        end
        set_in(2'b00, 1'b0, 1'b1, 32'hA4); settle();
        chk("t2_rvalid_last", 32'(rvalid_o), 32'h2);
        next_cyc();

        // Stalled address phase holds requester 0, then rotation resumes
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(2'b11, 1'b0, 1'b0, 32'h0); settle();
            chk("t3_stall_addr", m_addr_o, 32'h100);
            chk("t3_stall_gnt", 32'(gnt_o), 32'h0);
            next_cyc();
        end
        set_in(2'b11, 1'b1, 1'b0, 32'h0); settle();
        chk("t3_addr", m_addr_o, 32'h100);
        chk("t3_gnt", 32'(gnt_o), 32'h1);
        next_cyc();
        settle();
        chk("t3_next_gnt", 32'(gnt_o), 32'h2);
        next_cyc();
        for (int k = 0; k < 2; k++) begin
            set_in(2'b00, 1'b0, 1'b1, 32'hC0 + 32'(k));
            next_cyc();
        end

        // Outstanding limit and resume after a response
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(2'b01, 1'b1, 1'b0, 32'h0);
            next_cyc();
        end
        set_in(2'b01, 1'b1, 1'b1, 32'h5555_0000); settle();
        chk("t4_full_m_req", 32'(m_req_o), 32'd0);
        chk("t4_full_busy", 32'(busy_o), 32'd1);
        chk("t4_full_gnt", 32'(gnt_o), 32'h0);
        chk("t4_rvalid", 32'(rvalid_o), 32'h1);
        next_cyc();
        set_in(2'b01, 1'b1, 1'b0, 32'h0); settle();
        chk("t4_resume_m_req", 32'(m_req_o), 32'd1);
        chk("t4_resume_gnt", 32'(gnt_o), 32'h1);
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            set_in(2'b00, 1'b0, 1'b1, 32'h5555_0001 + 32'(k));
            next_cyc();
        end

        // In-order response routing for grants 0,1,1
        do_reset();
        set_in(2'b01, 1'b1, 1'b0, 32'h0); next_cyc();
        set_in(2'b10, 1'b1, 1'b0, 32'h0); next_cyc();
        set_in(2'b10, 1'b1, 1'b0, 32'h0); next_cyc();
        for (int k = 0; k < 3; k++) begin
            set_in(2'b00, 1'b0, 1'b1, 32'hB000_0000 + 32'(k)); settle();
            chk("t5_rvalid", 32'(rvalid_o), (k == 0) ? 32'h1 : 32'h2);
            next_cyc();
        end

        // Spurious response, sticky error, asynchronous reset mid-operation
        do_reset();
        set_in(2'b00, 1'b0, 1'b1, 32'h1234); settle();
        chk("t6_spur_rvalid", 32'(rvalid_o), 32'h0);
        next_cyc();
        set_in(2'b10, 1'b1, 1'b0, 32'h0); settle();
        chk("t6_err_set", 32'(err_o), 32'd1);
        next_cyc();
        set_in(2'b00, 1'b0, 1'b0, 32'h0); settle();
        chk("t6_err_sticky", 32'(err_o), 32'd1);
        chk("t6_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_err", 32'(err_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        set_in(2'b00, 1'b0, 1'b1, 32'h4321); settle();
        chk("t6_post_rst_rvalid", 32'(rvalid_o), 32'h0);
        next_cyc();
        set_in(2'b00, 1'b0, 1'b0, 32'h0); settle();
        chk("t6_post_rst_err", 32'(err_o), 32'd1);
        next_cyc();

        // Randomised traffic obeying hold-until-grant, checked by the model
        do_reset();
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    addr_s[k] = $urandom;
                    wdata_s[k] = $urandom;
                    be_s[k] = 4'($urandom_range(0, 15));
                    we_i[k] = 1'($urandom_range(0, 1));
                end
            end
            set_in(pend, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom);
            settle();
            pend = pend & ~gnt_o;
            next_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
